elevator_motion_ctrl: RTL and testbench
=======================================

// Module: elevator_motion_ctrl
// PURPOSE
//  Downstream consumer of the floor-request stage. Takes the latched request code
//  n_stage and its pending flag NextStageDelay, then moves the cab floor by floor
//  with a travel timer and holds the door open for a timed dwell.
//  Finally it drives DoneNextStage back to the request stage, which clears the
//  request. Four floors (0-3). Cab position and motion flags feed the display logic.
// PARAMETERS
//  TRAVEL_CYCLES  50_000_000  clk cycles to move one floor (>=1)
//  DOOR_CYCLES    100_000_000 clk cycles door stays open (>=1)
//  CNT_W          27          timer width; must hold max(TRAVEL_CYCLES,DOOR_CYCLES)-1
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  n_stage        in   3  request code; bit2=1 means valid, [1:0]=target floor
//  NextStageDelay in   1  0 = request pending, 1 = request cleared/acknowledged
//  DoneNextStage  out  1  high while a request is complete and awaiting clear
//  cur_floor      out  2  current cab floor
//  moving_up      out  1  high in MOVE_UP
//  moving_down    out  1  high in MOVE_DOWN
//  door_open      out  1  high in DOOR
//  busy           out  1  high in any state except IDLE
// BEHAVIOUR
//  - One clock, clk. rst_n is asynchronous and active-low; all flops clear immediately on assertion.
//    - Reset values: state=IDLE, cur_floor=0, target=0, timer=0, all outputs 0.
//  - req_valid = (NextStageDelay==0) && n_stage[2]. Codes 0-3 are never requests.
//  - All outputs are registered or decoded from registered state; no input-to-output combinational path.
//  - States and transitions:
//    - IDLE: on req_valid, latch target=n_stage[1:0] and clear timer.
//      - Next state is MOVE_UP if target>cur_floor, MOVE_DOWN if target<cur_floor,
//        DOOR if target==cur_floor.
//    - MOVE_UP/MOVE_DOWN: timer increments each cycle.
//      - At timer==TRAVEL_CYCLES-1: cur_floor +/-1, timer=0.
//      - If the new floor==target, go to DOOR; otherwise stay.
//      - cur_floor never wraps; it is bounded by construction since target is 0-3.
//    - DOOR: door_open=1. At timer==DOOR_CYCLES-1: timer=0, go to DONE.
//    - DONE: DoneNextStage=1 (level).
//      - Go to IDLE when NextStageDelay==1.
//      - Also go to IDLE when req_valid && n_stage[1:0]!=target. This covers a new
//        button that overrode the clear in the same cycle; that request is then
//        served from IDLE on the following cycle.
//  - Latency: a request seen in IDLE at edge k gives a state change and motion flag
//    at edge k+1.
//    - Moving d floors takes d*TRAVEL_CYCLES cycles, then the door opens.
//  - Request changes while busy (MOVE/DOOR) are ignored; target stays latched.
//  - A same-floor request goes straight to DOOR with no motion.
//  - Reset mid-operation: the cab position is lost and cur_floor returns to 0.
//    The bench checks outputs are 0 asynchronously, before the next clk edge.
//  - Exactly one of moving_up, moving_down, door_open, DoneNextStage is high when busy.
// TESTING  (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
//  1 Reset, then n_stage=7, NextStageDelay=0 at floor 0
//    -> moving_up high for 12 cycles; cur_floor 1,2,3 every 4 cycles;
//       door_open 3 cycles; DoneNextStage high until NextStageDelay=1, then IDLE.
//  2 At floor 0, n_stage=4, NextStageDelay=0
//    -> no motion flag; door_open next cycle for 3 cycles; then DoneNextStage.
//  3 At floor 3, n_stage=5 -> moving_down 8 cycles; cur_floor 2 then 1; door, done.
//  4 Going 0->3, change n_stage to 4 after 2 cycles -> ignored; cab still reaches 3.
//  5 n_stage=2, NextStageDelay=0 in IDLE -> busy stays 0. Assert rst_n=0 while
//    moving at floor 2 -> cur_floor=0 and outputs 0 without a clk edge.
//  6 In DONE at floor 3, NextStageDelay stays 0 and n_stage becomes 4
//    -> DoneNextStage drops; IDLE one cycle; then moving_down toward floor 0.

Source files
------------

// File: rtl/elevator_motion_ctrl.sv
// Elevator cab motion controller: consumes a latched floor request, travels floor by
// floor on a timer, dwells with the door open, then signals completion upstream.
module elevator_motion_ctrl #(
    parameter int TRAVEL_CYCLES = 50_000_000,
    parameter int DOOR_CYCLES   = 100_000_000,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] n_stage,
    input  logic       NextStageDelay,
    output logic       DoneNextStage,
    output logic [1:0] cur_floor,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       floor_q, floor_d;
    logic [1:0]       target_q, target_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    logic       req_valid;
    logic [1:0] req_floor;
    logic [1:0] floor_up, floor_dn;
    logic       travel_done, dwell_done;

    assign req_valid   = !NextStageDelay && n_stage[2];
    assign req_floor   = n_stage[1:0];
    assign floor_up    = floor_q + 2'd1;
    assign floor_dn    = floor_q - 2'd1;
    assign travel_done = (timer_q == TRAVEL_LAST);
    assign dwell_done  = (timer_q == DOOR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            floor_q  <= 2'd0;
            target_q <= 2'd0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            target_q <= target_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        target_d = target_q;
        timer_d  = timer_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_floor;
                    timer_d  = '0;
                    if (req_floor > floor_q)      state_d = MOVE_UP;
                    else if (req_floor < floor_q) state_d = MOVE_DOWN;
                    else                          state_d = DOOR;
                end
            end
            // Target is 0-3 and motion direction is chosen against it, so the
            // floor arithmetic below can never wrap.
            MOVE_UP: begin
                if (travel_done) begin
                    timer_d = '0;
                    floor_d = floor_up;
                    if (floor_up == target_q) state_d = DOOR;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            MOVE_DOWN: begin
                if (travel_done) begin
                    timer_d = '0;
                    floor_d = floor_dn;
                    if (floor_dn == target_q) state_d = DOOR;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            DOOR: begin
                if (dwell_done) begin
                    timer_d = '0;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            DONE: begin
                // A different button pressed before the clear lands is served
                // from IDLE on the next cycle.
                if (NextStageDelay || (req_valid && (req_floor != target_q)))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign DoneNextStage = (state_q == DONE);
    assign cur_floor     = floor_q;
    assign moving_up     = (state_q == MOVE_UP);
    assign moving_down   = (state_q == MOVE_DOWN);
    assign door_open     = (state_q == DOOR);
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed, table-driven bench for elevator_motion_ctrl with short travel/door timers.
module tb_elevator_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] n_stage;
    logic       NextStageDelay;
    logic       DoneNextStage;
    logic [1:0] cur_floor;
    logic       moving_up, moving_down, door_open, busy;

    int checks = 0;
    int errors = 0;

    elevator_motion_ctrl #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (3),
        .CNT_W        (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .n_stage       (n_stage),
        .NextStageDelay(NextStageDelay),
        .DoneNextStage (DoneNextStage),
        .cur_floor     (cur_floor),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .door_open     (door_open),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // {done, floor[1:0], up, down, door, busy}
    logic [6:0] obs;
    assign obs = {DoneNextStage, cur_floor, moving_up, moving_down, door_open, busy};

    typedef struct {
        string      tag;
        logic [2:0] ns;
        logic       nsd;
        int         cyc;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    localparam int S_IDLE = 0, S_UP = 1, S_DN = 2, S_DOOR = 3, S_DONE = 4;

    function automatic logic [6:0] ex(input int st, input logic [1:0] fl);
        case (st)
            S_UP:    return {1'b0, fl, 4'b1001};
            S_DN:    return {1'b0, fl, 4'b0101};
            S_DOOR:  return {1'b0, fl, 4'b0011};
            S_DONE:  return {1'b1, fl, 4'b0001};
            default: return {1'b0, fl, 4'b0000};
        endcase
    endfunction

    task automatic add(input string tag, input logic [2:0] ns, input logic nsd,
                       input int cyc, input int st, input logic [1:0] fl);
        vec_t v;
        v.tag = tag; v.ns = ns; v.nsd = nsd; v.cyc = cyc; v.exp = ex(st, fl);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [6:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (done,floor,up,down,door,busy)", name, obs, exp);
        end
    endtask

    initial begin
        // 1: 0 -> 3, three floors up, door, hold done until cleared
        add("t1_up0",  3'd7, 1'b0, 4, S_UP,   2'd0);
        add("t1_up1",  3'd7, 1'b0, 4, S_UP,   2'd1);
        add("t1_up2",  3'd7, 1'b0, 4, S_UP,   2'd2);
        add("t1_door", 3'd7, 1'b0, 3, S_DOOR, 2'd3);
        add("t1_done", 3'd7, 1'b0, 2, S_DONE, 2'd3);
        add("t1_clr",  3'd7, 1'b1, 1, S_IDLE, 2'd3);
        add("t1_idle", 3'd7, 1'b1, 2, S_IDLE, 2'd3);
        // 3: 3 -> 1 downward
        add("t3_dn3",  3'd5, 1'b0, 4, S_DN,   2'd3);
        add("t3_dn2",  3'd5, 1'b0, 4, S_DN,   2'd2);
        add("t3_door", 3'd5, 1'b0, 3, S_DOOR, 2'd1);
        add("t3_done", 3'd5, 1'b0, 1, S_DONE, 2'd1);
        add("t3_clr",  3'd5, 1'b1, 1, S_IDLE, 2'd1);
        // back to floor 0
        add("g0_dn1",  3'd4, 1'b0, 4, S_DN,   2'd1);
        add("g0_door", 3'd4, 1'b0, 3, S_DOOR, 2'd0);
        add("g0_done", 3'd4, 1'b0, 1, S_DONE, 2'd0);
        add("g0_clr",  3'd4, 1'b1, 1, S_IDLE, 2'd0);
        // 2: same-floor request, no motion
        add("t2_door", 3'd4, 1'b0, 3, S_DOOR, 2'd0);
        add("t2_done", 3'd4, 1'b0, 2, S_DONE, 2'd0);
        add("t2_clr",  3'd4, 1'b1, 1, S_IDLE, 2'd0);
        // 5a: invalid code and cleared request never start
        add("t5_noreq",   3'd2, 1'b0, 3, S_IDLE, 2'd0);
        add("t5_cleared", 3'd6, 1'b1, 2, S_IDLE, 2'd0);
        // 4: request changed mid-move is ignored
        add("t4_up0a", 3'd7, 1'b0, 2, S_UP,   2'd0);
        add("t4_up0b", 3'd4, 1'b0, 2, S_UP,   2'd0);
        add("t4_up1",  3'd4, 1'b0, 4, S_UP,   2'd1);
        add("t4_up2",  3'd4, 1'b0, 4, S_UP,   2'd2);
        add("t4_door", 3'd4, 1'b0, 2, S_DOOR, 2'd3);
        add("t4_dr3",  3'd7, 1'b0, 1, S_DOOR, 2'd3);
        // 6: new request overrides the clear while in DONE
        add("t6_done", 3'd7, 1'b0, 2, S_DONE, 2'd3);
        add("t6_over", 3'd4, 1'b0, 1, S_IDLE, 2'd3);
        add("t6_dn3",  3'd4, 1'b0, 4, S_DN,   2'd3);
        add("t6_dn2",  3'd4, 1'b0, 4, S_DN,   2'd2);
        add("t6_dn1",  3'd4, 1'b0, 4, S_DN,   2'd1);
        add("t6_door", 3'd4, 1'b0, 3, S_DOOR, 2'd0);
        add("t6_fin",  3'd4, 1'b0, 1, S_DONE, 2'd0);
        add("t6_clr",  3'd4, 1'b1, 1, S_IDLE, 2'd0);

        rst_n = 1'b0;
        n_stage = 3'd0;
        NextStageDelay = 1'b1;
        #3;
        check("reset_state", ex(S_IDLE, 2'd0));
        #19 rst_n = 1'b1;

        foreach (tbl[i]) begin
            n_stage = tbl[i].ns;
            NextStageDelay = tbl[i].nsd;
            for (int c = 0; c < tbl[i].cyc; c++) begin
                @(posedge clk);
                #1;
                check($sformatf("%s[%0d]", tbl[i].tag, c), tbl[i].exp);
            end
        end

        // 5b: asynchronous reset while moving up at floor 2
        n_stage = 3'd7;
        NextStageDelay = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_floor2", ex(S_UP, 2'd2));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", ex(S_IDLE, 2'd0));
        #2 rst_n = 1'b1;
        n_stage = 3'd6;
        @(posedge clk);
        #1;
        check("post_reset_start", ex(S_UP, 2'd0));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
        end
        check("post_reset_floor1", ex(S_UP, 2'd1));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
        end
        check("post_reset_arrive", ex(S_DOOR, 2'd2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
